// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the 8-way round-robin bus arbiter.
//   N_REQ       - number of requesters
//   SEL_W       - width of the mux select / requester index
//   CNT_W       - width of the grant hold counter
//   arb_state_t - arbiter FSM state
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin selector.
//   req [7:0] in  - request lines
//   ptr [2:0] in  - index with highest priority this round
//   any       out - at least one request is set
//   idx [2:0] out - first set request at or above ptr, wrapping 7 -> 0
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    logic               found;

    always_comb begin
        // Rotate right by ptr so that rot[j] == req[(ptr + j) mod 8].
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
        any = |req;
        // Un-rotate: 3-bit addition wraps naturally modulo 8.
        idx = ptr + off;
    end

endmodule : rr_pick8

// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter/sequencer driving an 8:1 mux select.
//   clk      in  - rising-edge clock
//   reset_n  in  - asynchronous active-low reset
//   req[7:0] in  - level-sensitive request lines
//   done     in  - owner releases the resource (only honoured while busy)
//   gnt[7:0] out - registered one-hot grant, zero when idle
//   sel[2:0] out - registered index of the granted requester (holds after release)
//   busy     out - registered, high while a grant is held
//   timeout  out - registered one-cycle pulse after a watchdog release
// Parameter MAX_HOLD (2..255): maximum grant length in cycles.
module bus_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= N_REQ'(1) << pick_idx;
                        sel   <= pick_idx;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    // done takes precedence over the watchdog on the same cycle.
                    if (done || (cnt == CNT_LAST)) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= sel + 1'b1;
                        timeout <= !done;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : bus_arbiter8

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: self-checking bench for bus_arbiter8 (MAX_HOLD = 16).
// A behavioural model tracks owner, hold length and priority pointer and is
// compared against the DUT every falling edge; directed sequences add literal
// expectations, followed by a randomized phase.
module tb_bus_arbiter8;

    localparam int unsigned MH = 16;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bus_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int unsigned m_owner;
    int unsigned m_ptr;
    int unsigned m_held;   // cycles the current grant has been visible
    bit          m_to;

    initial begin
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
            end else begin
                m_to = 0;
                if (!m_busy) begin
                    for (int k = 0; k < 8; k++) begin
                        int unsigned c;
                        c = (m_ptr + k) % 8;
                        if (!m_busy && req[c]) begin
                            m_busy  = 1;
                            m_owner = c;
                            m_held  = 1;
                        end
                    end
                end else if (done || m_held == MH) begin
                    m_to   = !done;
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 8;
                end else begin
                    m_held++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_gnt", {24'd0, gnt}, m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("model_sel", {29'd0, sel}, m_owner);
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        req  = '0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("reset_gnt", {24'd0, gnt}, 32'h00);
        chk("reset_sel", {29'd0, sel}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_timeout", {31'd0, timeout}, 0);

        // Single request
        req = 8'h10;
        tick();
        chk("single_gnt", {24'd0, gnt}, 32'h10);
        chk("single_sel", {29'd0, sel}, 4);
        chk("single_busy", {31'd0, busy}, 1);
        req = 8'h00; done = 1'b1;
        tick();
        done = 1'b0;
        chk("single_release_gnt", {24'd0, gnt}, 32'h00);
        chk("single_release_sel_hold", {29'd0, sel}, 4);
        // ptr is now 5: bits 0 and 5 requested, 5 must win
        req = 8'h21;
        tick();
        chk("ptr_after_release", {29'd0, sel}, 5);
        req = 8'h00; done = 1'b1;
        tick();
        done = 1'b0;

        // Round-robin rotation with one idle bubble between grants
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr_sel", {29'd0, sel}, i % 8);
            chk("rr_gnt", {24'd0, gnt}, 32'd1 << (i % 8));
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rr_bubble", {31'd0, busy}, 0);
        end
        // ptr is now 1

        // Wrap-around and skip
        req = 8'h40;
        tick();
        chk("wrap_sel6", {29'd0, sel}, 6);
        done = 1'b1; req = 8'h05;
        tick();
        done = 1'b0;
        tick();
        chk("wrap_sel0", {29'd0, sel}, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("skip_sel2", {29'd0, sel}, 2);
        done = 1'b1; req = 8'h00;
        tick();
        done = 1'b0;

        // Watchdog: requester 3 drops req mid-grant, grant still held 16 cycles
        req = 8'h08;
        tick();
        chk("wd_sel", {29'd0, sel}, 3);
        req = 8'h00;
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk("wd_hold_gnt", {24'd0, gnt}, 32'h08);
        end
        tick();
        chk("wd_release_gnt", {24'd0, gnt}, 32'h00);
        chk("wd_release_busy", {31'd0, busy}, 0);
        chk("wd_timeout_pulse", {31'd0, timeout}, 1);
        req = 8'h18;
        tick();
        chk("wd_timeout_one_cycle", {31'd0, timeout}, 0);
        chk("wd_next_from4", {29'd0, sel}, 4);

        // done coincident with watchdog cycle: release without timeout
        req = 8'h00;
        repeat (15) tick();
        chk("coin_still_busy", {31'd0, busy}, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("coin_busy", {31'd0, busy}, 0);
        chk("coin_timeout", {31'd0, timeout}, 0);

        // done in IDLE has no effect
        done = 1'b1;
        repeat (3) tick();
        chk("idle_done_busy", {31'd0, busy}, 0);
        chk("idle_done_timeout", {31'd0, timeout}, 0);
        done = 1'b0;
        req = 8'h21;   // ptr is 5
        tick();
        chk("idle_done_ptr", {29'd0, sel}, 5);
        done = 1'b1; req = 8'h00;
        tick();
        done = 1'b0;

        // Randomized phase, checked by the model
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'(1 << $urandom_range(0, 7));
                default: req = 8'($urandom);
            endcase
            done = ($urandom_range(0, 5) == 0);
            tick();
        end
        req = 8'h00; done = 1'b0;
        tick();

        // Async reset mid-grant
        req = 8'hFF;
        begin
            int unsigned w;
            w = 0;
            while (!busy && w < 20) begin
                tick();
                w++;
            end
            chk("async_got_grant", {31'd0, busy}, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_gnt", {24'd0, gnt}, 32'h00);
        chk("async_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("post_reset_sel", {29'd0, sel}, 0);
        chk("post_reset_gnt", {24'd0, gnt}, 32'h01);
        req = 8'h00; done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter8
